// File: rtl/holo_lsu_if.sv
// Core-side request/response and data-memory beat bundle for holo_lsu.
// slave: LSU side; master: core plus memory side driving the LSU.
interface holo_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int BUS_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_f3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [BUS_W-1:0]  mem_wdata;
  logic [BUS_W/8-1:0] mem_be;
  logic              mem_oe;
  logic              mem_we;
  logic [BUS_W-1:0]  mem_rdata;
  logic              mem_ack;

  modport slave (
    input  req_valid, req_we, req_f3,
    input  req_addr, req_wdata,
    input  mem_rdata, mem_ack,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_wdata, mem_be,
    output mem_oe, mem_we
  );

  modport master (
    output req_valid, req_we, req_f3,
    output req_addr, req_wdata,
    output mem_rdata, mem_ack,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_wdata, mem_be,
    input  mem_oe, mem_we
  );
endinterface

// File: rtl/holo_lsu.sv
// RV32I load/store unit: one request -> 1..4 beats on a BUS_W port.
// Ports: clk, rst_n, bus (holo_lsu_if.slave: req/rsp + mem beats).
module holo_lsu #(
  parameter int ADDR_W  = 32,
  parameter int BUS_W   = 8,
  parameter int TIMEOUT = 15
) (
  input logic       clk,
  input logic       rst_n,
  holo_lsu_if.slave bus
);
  localparam int BPB = BUS_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [1:0]  beat;
  logic [1:0]  last_q;
  logic [31:0] wsh_q;
  logic [31:0] rbuf;
  logic [7:0]  cnt;

  logic [2:0]        n;
  logic              bad_f3;
  logic              misal;
  logic [1:0]        lane;
  logic [1:0]        last;
  logic [3:0]        be4;
  logic [31:0]       wsh;
  logic [31:0]       rnext;
  logic [ADDR_W-1:0] base;

  always_comb begin
    n = 3'd4;
    unique case (1'b1)
      bus.req_f3[1:0] == 2'd0: n = 3'd1;
      bus.req_f3[1:0] == 2'd1: n = 3'd2;
      default:                 n = 3'd4;
    endcase
  end

  assign bad_f3 = (bus.req_f3[1:0] == 2'd3)
                | (bus.req_we ? bus.req_f3[2]
                              : (bus.req_f3 == 3'd6));
  assign misal = |(bus.req_addr[1:0] & (n[1:0] - 2'd1));
  assign lane  = bus.req_addr[1:0] & 2'(BPB - 1);
  assign base  = bus.req_addr & ~ADDR_W'(BPB - 1);
  assign last  = (int'(n) > BPB) ? 2'(int'(n) / BPB - 1)
                                 : 2'd0;
  // Sub-beat accesses land in lane addr%BPB; wide ones fill all lanes.
  assign be4   = 4'((5'd1 << n) - 5'd1) << lane;
  assign wsh   = bus.req_wdata << {lane, 3'b000};
  assign rnext = rbuf
    | ((32'(bus.mem_rdata) >> {lane_q, 3'b000})
       << (int'(beat) * BUS_W));

  function automatic logic [31:0] ext(
    input logic [31:0] r,
    input logic [2:0]  f3
  );
    logic s;
    s   = 1'b0;
    ext = r;
    unique case (1'b1)
      f3[1:0] == 2'd0: begin
        s   = r[7] & ~f3[2];
        ext = {{24{s}}, r[7:0]};
      end
      f3[1:0] == 2'd1: begin
        s   = r[15] & ~f3[2];
        ext = {{16{s}}, r[15:0]};
      end
      default: ext = r;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.mem_oe    <= 1'b0;
      bus.mem_we    <= 1'b0;
      we_q          <= 1'b0;
      f3_q          <= '0;
      lane_q        <= '0;
      beat          <= '0;
      last_q        <= '0;
      wsh_q         <= '0;
      rbuf          <= '0;
      cnt           <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            we_q   <= bus.req_we;
            f3_q   <= bus.req_f3;
            lane_q <= lane;
            last_q <= last;
            wsh_q  <= wsh;
            beat   <= '0;
            rbuf   <= '0;
            cnt    <= '0;
            if (bad_f3 || misal) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              state         <= ISSUE;
              bus.mem_addr  <= base;
              bus.mem_be    <= be4[BPB-1:0];
              bus.mem_wdata <= BUS_W'(wsh);
              bus.mem_oe    <= ~bus.req_we;
              bus.mem_we    <= bus.req_we;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_ack) begin
            rbuf <= rnext;
            cnt  <= '0;
            if (beat == last_q) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b0;
              bus.rsp_rdata <= we_q ? '0 : ext(rnext, f3_q);
              bus.mem_oe    <= 1'b0;
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= '0;
              bus.mem_be    <= '0;
              bus.mem_wdata <= '0;
            end else begin
              beat          <= beat + 2'd1;
              bus.mem_addr  <= bus.mem_addr + ADDR_W'(BPB);
              bus.mem_wdata <= BUS_W'(wsh_q
                >> ((int'(beat) + 1) * BUS_W));
            end
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
            bus.mem_oe    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_holo_lsu.sv
// Bench for holo_lsu: 8-bit and 32-bit bus instances vs a byte model.
// Ports: none; drives both DUTs through holo_lsu_if instances.
module tb_holo_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  holo_lsu_if #(.ADDR_W(32), .BUS_W(8))  if8 ();
  holo_lsu_if #(.ADDR_W(32), .BUS_W(32)) if32 ();

  holo_lsu #(.ADDR_W(32), .BUS_W(8), .TIMEOUT(15)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave));
  holo_lsu #(.ADDR_W(32), .BUS_W(32), .TIMEOUT(15)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(if32.slave));

  logic [1:0]  rq_valid = '0;
  logic        rq_we = 1'b0;
  logic [2:0]  rq_f3 = '0;
  logic [31:0] rq_addr = '0;
  logic [31:0] rq_wdata = '0;

  assign if8.req_valid  = rq_valid[0];
  assign if8.req_we     = rq_we;
  assign if8.req_f3     = rq_f3;
  assign if8.req_addr   = rq_addr;
  assign if8.req_wdata  = rq_wdata;
  assign if32.req_valid = rq_valid[1];
  assign if32.req_we    = rq_we;
  assign if32.req_f3    = rq_f3;
  assign if32.req_addr  = rq_addr;
  assign if32.req_wdata = rq_wdata;

  logic [1:0]  rdy, rv, rer, stb;
  logic [31:0] rdt [2];
  assign rdy = {if32.req_ready, if8.req_ready};
  assign rv  = {if32.rsp_valid, if8.rsp_valid};
  assign rer = {if32.rsp_err, if8.rsp_err};
  assign stb = {if32.mem_oe | if32.mem_we,
                if8.mem_oe | if8.mem_we};
  assign rdt[0] = if8.rsp_rdata;
  assign rdt[1] = if32.rsp_rdata;

  int rnd = 0;
  int fdly = 0;
  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mm0 [64];
  logic [7:0] mm1 [64];
  logic [7:0] rm [2][64];
  int w0 = 0;
  int w1 = 0;
  int sc0 = 0;
  int sc1 = 0;
  int qa0 [$];
  int qa1 [$];
  logic [3:0] qb0 [$];
  logic [3:0] qb1 [$];

  always @(negedge clk) begin
    if8.mem_ack = (if8.mem_oe | if8.mem_we)
      && (w0 >= fdly || (rnd != 0 && $urandom_range(0, 1) == 1));
    if8.mem_rdata = mm0[if8.mem_addr[5:0]];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0 <= 0;
    end else if (if8.mem_oe | if8.mem_we) begin
      sc0 <= sc0 + 1;
      if (if8.mem_ack) begin
        w0 <= 0;
        qa0.push_back(int'(if8.mem_addr));
        qb0.push_back(4'(if8.mem_be));
        if (if8.mem_we && if8.mem_be[0])
          mm0[if8.mem_addr[5:0]] <= if8.mem_wdata;
      end else begin
        w0 <= w0 + 1;
      end
    end else begin
      w0 <= 0;
    end
  end

  always @(negedge clk) begin
    if32.mem_ack = (if32.mem_oe | if32.mem_we)
      && (w1 >= fdly || (rnd != 0 && $urandom_range(0, 1) == 1));
    if32.mem_rdata = {mm1[if32.mem_addr[5:0] + 6'd3],
                      mm1[if32.mem_addr[5:0] + 6'd2],
                      mm1[if32.mem_addr[5:0] + 6'd1],
                      mm1[if32.mem_addr[5:0]]};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w1 <= 0;
    end else if (if32.mem_oe | if32.mem_we) begin
      sc1 <= sc1 + 1;
      if (if32.mem_ack) begin
        w1 <= 0;
        qa1.push_back(int'(if32.mem_addr));
        qb1.push_back(if32.mem_be);
        for (int i = 0; i < 4; i++)
          if (if32.mem_we && if32.mem_be[i])
            mm1[if32.mem_addr[5:0] + 6'(i)] <= if32.mem_wdata[8*i +: 8];
      end else begin
        w1 <= w1 + 1;
      end
    end else begin
      w1 <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] memb(input int sel, input int a);
    return sel != 0 ? mm1[a] : mm0[a];
  endfunction

  // One request on bus sel, checked against the byte-array model rm.
  task automatic run(input int sel, input logic we,
                     input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd);
    int n, bpb, nb, d, lat, a0, sc_b, nlog, elat, esc, ia, wb;
    logic ok, tmo, eerr;
    logic [31:0] er;
    logic [3:0] ebe;
    bpb = sel != 0 ? 4 : 1;
    ia  = int'(addr);
    n   = 1 << f3[1:0];
    ok  = we ? (f3 <= 3'd2) : (f3 inside {0, 1, 2, 4, 5});
    if (ia % n != 0) ok = 1'b0;
    nb  = (n > bpb) ? n / bpb : 1;
    d   = fdly + 1;
    tmo = ok && rnd == 0 && d > 15;
    eerr = !ok || tmo;
    er  = '0;
    if (ok && !we && !tmo) begin
      for (int i = 0; i < n; i++)
        er |= 32'(rm[sel][ia + i]) << (8 * i);
      if (!f3[2] && n < 4 && er[8*n-1])
        er |= ~((32'd1 << (8 * n)) - 32'd1);
    end
    if (n >= bpb) ebe = 4'((1 << bpb) - 1);
    else ebe = 4'(((1 << n) - 1) << (ia % bpb));
    a0   = sel != 0 ? qa1.size() : qa0.size();
    sc_b = sel != 0 ? sc1 : sc0;
    @(negedge clk);
    chk("ready_idle", 32'(rdy[sel]), 32'd1);
    rq_we = we;
    rq_f3 = f3;
    rq_addr = addr;
    rq_wdata = wd;
    rq_valid[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rq_valid = '0;
    lat = 1;
    while (!rv[sel] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_seen", 32'(rv[sel]), 32'd1);
    chk("rsp_rdata", rdt[sel], er);
    chk("rsp_err", 32'(rer[sel]), 32'(eerr));
    if (rnd == 0 || !ok) begin
      elat = !ok ? 1 : (tmo ? 16 : 1 + nb * d);
      esc  = !ok ? 0 : (tmo ? 15 : nb * d);
      chk("latency", 32'(lat), 32'(elat));
      chk("strobe_cycles",
          32'((sel != 0 ? sc1 : sc0) - sc_b), 32'(esc));
    end
    nlog = (sel != 0 ? qa1.size() : qa0.size()) - a0;
    chk("beat_count", 32'(nlog), 32'((ok && !tmo) ? nb : 0));
    for (int k = 0; k < nlog && k < 4; k++) begin
      wb = (n <= bpb) ? (ia & ~(bpb - 1)) : ia + k * bpb;
      chk("beat_addr",
          32'(sel != 0 ? qa1[a0+k] : qa0[a0+k]), 32'(wb));
      chk("beat_be",
          32'(sel != 0 ? qb1[a0+k] : qb0[a0+k]), 32'(ebe));
    end
    @(negedge clk);
    chk("rsp_pulse", 32'(rv[sel]), 32'd0);
    chk("ready_next", 32'(rdy[sel]), 32'd1);
    if (we) begin
      if (ok && !tmo)
        for (int i = 0; i < n; i++)
          rm[sel][ia + i] = wd[8*i +: 8];
      for (int i = 0; i < 4; i++)
        chk("mem_byte", 32'(memb(sel, (ia & ~3) + i)),
            32'(rm[sel][(ia & ~3) + i]));
    end
  endtask

  initial begin
    int pulses;
    int n;
    logic [31:0] a;
    logic [2:0] f3;
    logic we;
    int sel;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready8", 32'(if8.req_ready), 32'd1);
    chk("rst_ready32", 32'(if32.req_ready), 32'd1);
    chk("rst_rsp", 32'({if8.rsp_valid, if8.rsp_err,
                         if32.rsp_valid, if32.rsp_err}), 32'd0);
    chk("rst_rdata", if8.rsp_rdata | if32.rsp_rdata, 32'd0);
    chk("rst_strobe", 32'(stb), 32'd0);
    chk("rst_maddr", if8.mem_addr | if32.mem_addr, 32'd0);
    chk("rst_mwd", 32'(if8.mem_wdata) | if32.mem_wdata, 32'd0);
    chk("rst_mbe", 32'({if8.mem_be, if32.mem_be}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i += 4) begin
      run(0, 1'b1, 3'd2, 32'(i), $urandom);
      run(1, 1'b1, 3'd2, 32'(i), $urandom);
    end

    run(0, 1'b1, 3'd2, 32'h4, 32'h1234_5678);
    run(0, 1'b0, 3'd2, 32'h4, 32'h0);
    chk("lw_value", rdt[0], 32'h1234_5678);
    run(0, 1'b1, 3'd0, 32'h3, 32'h80);
    run(0, 1'b0, 3'd0, 32'h3, 32'h0);
    chk("lb_value", rdt[0], 32'hFFFF_FF80);
    run(0, 1'b0, 3'd4, 32'h3, 32'h0);
    chk("lbu_value", rdt[0], 32'h0000_0080);
    run(0, 1'b1, 3'd1, 32'h2, 32'h0000_F234);
    run(0, 1'b0, 3'd5, 32'h2, 32'h0);
    chk("lhu_value", rdt[0], 32'h0000_F234);
    run(1, 1'b1, 3'd0, 32'h6, 32'hAB);
    chk("sb_addr", 32'(qa1[$]), 32'h4);
    chk("sb_be", 32'(qb1[$]), 32'h4);
    chk("sb_byte", 32'(mm1[6]), 32'hAB);
    run(1, 1'b0, 3'd2, 32'h4, 32'h0);

    run(0, 1'b0, 3'd1, 32'h1, 32'h0);
    run(1, 1'b0, 3'd3, 32'h0, 32'h0);
    run(1, 1'b1, 3'd1, 32'h9, 32'h55AA);
    run(0, 1'b1, 3'd4, 32'h8, 32'h77);

    fdly = 15;
    run(0, 1'b0, 3'd0, 32'h5, 32'h0);
    run(1, 1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF);
    fdly = 14;
    run(0, 1'b0, 3'd0, 32'h5, 32'h0);
    fdly = 1;
    run(0, 1'b0, 3'd2, 32'hC, 32'h0);
    fdly = 0;

    @(negedge clk);
    rq_we = 1'b0;
    rq_f3 = 3'd2;
    rq_addr = 32'h8;
    rq_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rq_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_strobe", 32'(stb[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_strobe", 32'(stb[0]), 32'd0);
    chk("arst_ready", 32'(rdy[0]), 32'd1);
    chk("arst_addr", if8.mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv[0]) pulses++;
    end
    chk("arst_no_rsp", 32'(pulses), 32'd0);
    run(0, 1'b0, 3'd2, 32'h8, 32'h0);

    for (int t = 0; t < 80; t++) begin
      sel = int'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      a   = 32'($urandom_range(0, 60));
      n   = 1 << f3[1:0];
      if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      rnd  = int'($urandom_range(0, 1));
      fdly = rnd != 0 ? 3 : int'($urandom_range(0, 2));
      run(sel, we, f3, a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
